// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use bubble insertion and mult/div sequencing for the FD/DX latches
module pipeline_hazard_ctrl #(
  parameter int MAX_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        md_busy,
  output logic        md_write,
  output logic        md_error,
  output logic        md_timeout
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_CYCLES - 1);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          err, err_nxt;
  logic          to, to_nxt;

  logic [4:0] fd_op, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  logic       dx_lw, dx_mul, dx_div, load_use;

  // Field bits that no decode here looks at.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{fd_ir[11:7], fd_ir[1:0], dx_ir[21:7], dx_ir[1:0]};

  // R-type reads rs/rt; everything else reads rs and the rd field (e.g. store data).
  assign fd_op  = fd_ir[31:27];
  assign fd_rs  = fd_ir[21:17];
  assign fd_rt  = (fd_op == OP_RTYPE) ? fd_ir[16:12] : fd_ir[26:22];

  assign dx_op  = dx_ir[31:27];
  assign dx_rd  = dx_ir[26:22];
  assign dx_alu = dx_ir[6:2];

  assign dx_lw    = (dx_op == OP_LW);
  assign dx_mul   = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_div   = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
  assign load_use = dx_lw && (dx_rd != 5'd0) && ((dx_rd == fd_rs) || (dx_rd == fd_rt));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      err   <= 1'b0;
      to    <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      err   <= err_nxt;
      to    <= to_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    err_nxt    = err;
    to_nxt     = to;
    stall_fd   = 1'b0;
    stall_dx   = 1'b0;
    bubble_dx  = 1'b0;
    ctrl_mult  = 1'b0;
    ctrl_div   = 1'b0;
    md_busy    = 1'b0;
    md_write   = 1'b0;
    md_error   = 1'b0;
    md_timeout = 1'b0;

    case (state)
      IDLE: begin
        if (dx_mul || dx_div) begin
          ctrl_mult = dx_mul;
          ctrl_div  = dx_div;
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          count_nxt = '0;
          state_nxt = BUSY;
        end else if (load_use) begin
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end

      BUSY: begin
        md_busy   = 1'b1;
        stall_fd  = 1'b1;
        stall_dx  = 1'b1;
        count_nxt = count + CW'(1);
        // A result arriving on the last allowed cycle still beats the timeout.
        if (md_ready) begin
          err_nxt   = md_exception;
          to_nxt    = 1'b0;
          state_nxt = DONE;
        end else if (count == LAST_COUNT) begin
          err_nxt   = 1'b1;
          to_nxt    = 1'b1;
          state_nxt = DONE;
        end
      end

      DONE: begin
        // DX still holds the finished mul/div here; returning to IDLE without a
        // start pulse lets it leave DX on this edge.
        md_write   = 1'b1;
        md_error   = err;
        md_timeout = to;
        state_nxt  = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!reset_n) begin
      stall_fd   = 1'b0;
      stall_dx   = 1'b0;
      bubble_dx  = 1'b0;
      ctrl_mult  = 1'b0;
      ctrl_div   = 1'b0;
      md_busy    = 1'b0;
      md_write   = 1'b0;
      md_error   = 1'b0;
      md_timeout = 1'b0;
    end
  end

endmodule
